alu_seq_32: RTL and testbench

ALU_SEQ_32 -- requirements
Module: alu_seq_32

---
 rtl/alu_seq_32.sv | 147 ++++++++++++++
 tb/tb_alu_seq_32.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq_32.sv
// Sequential 32-bit ALU: single-cycle logic/arith ops and a 32-step shift-add
// unsigned multiplier, with a one-cycle done pulse and held outputs.
module alu_seq_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic        zero
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 5;
  localparam logic [2:0]  OP_AND  = 3'b000;
  localparam logic [2:0]  OP_OR   = 3'b001;
  localparam logic [2:0]  OP_XOR  = 3'b010;
  localparam logic [2:0]  OP_NOR  = 3'b011;
  localparam logic [2:0]  OP_ADD  = 3'b100;
  localparam logic [2:0]  OP_SUB  = 3'b101;
  localparam logic [2:0]  OP_SLT  = 3'b110;
  localparam logic [2:0]  OP_MULT = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d, zero_q, zero_d;
  logic [W-1:0]    result_q, result_d, hi_q, hi_d;
  logic [W-1:0]    alu_c;
  logic [W:0]      mul_sum_c;
  logic [2*W-1:0]  mul_next_c;

  // Single-cycle operations on the latched operands
  always_comb begin
    alu_c = '0;
    unique case (op_q)
      OP_AND:  alu_c = a_q & b_q;
      OP_OR:   alu_c = a_q | b_q;
      OP_XOR:  alu_c = a_q ^ b_q;
      OP_NOR:  alu_c = ~(a_q | b_q);
      OP_ADD:  alu_c = a_q + b_q;
      OP_SUB:  alu_c = a_q + ~b_q + W'(1);
      OP_SLT:  alu_c = W'($signed(a_q) < $signed(b_q));
      default: alu_c = '0;
    endcase
  end

  // One shift-add step: acc = {partial product, remaining multiplier bits}
  always_comb begin
    mul_sum_c  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : (W+1)'(0));
    mul_next_c = {mul_sum_c, acc_q[W-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          acc_d   = {W'(0), b};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = (op == OP_MULT) ? MUL : EXEC;
        end
      end
      EXEC: begin
        result_d = alu_c;
        hi_d     = '0;
        zero_d   = (alu_c == '0);
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      MUL: begin
        acc_d = mul_next_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          result_d = mul_next_c[W-1:0];
          hi_d     = mul_next_c[2*W-1:W];
          zero_d   = (mul_next_c[W-1:0] == '0);
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign hi     = hi_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_seq_32.sv
// Self-checking bench for alu_seq_32: vector table plus random ops through a
// scoreboard queue, and directed sequences for ignored inputs and mid-op reset.
module tb_alu_seq_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, zero;
  logic [31:0] result, hi;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    int          lat;
    int          bcyc;
  } exp_t;

  exp_t sb[$];

  alu_seq_32 dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .hi(hi), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      3'd0: return {32'h0, x & y};
      3'd1: return {32'h0, x | y};
      3'd2: return {32'h0, x ^ y};
      3'd3: return {32'h0, ~(x | y)};
      3'd4: return {32'h0, x + y};
      3'd5: return {32'h0, x - y};
      3'd6: return {32'h0, 31'h0, ($signed(x) < $signed(y))};
      default: return 64'(x) * 64'(y);
    endcase
  endfunction

  // Caller is #1 after a posedge with the DUT in IDLE.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eres, input logic [31:0] ehi,
                        input bit disturb);
    exp_t e, g;
    int n, bc;
    logic [31:0] held;
    e.res = eres; e.hi = ehi; e.z = (eres == 32'h0);
    e.lat = (o == 3'b111) ? 33 : 2;
    e.bcyc = (o == 3'b111) ? 32 : 1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    sb.push_back(e);
    start = disturb;
    if (disturb) begin a = $urandom; b = $urandom; op = 3'($urandom); end
    chk({name, " busy_rise"}, 64'(busy), 64'd1);
    n = 1; bc = busy ? 1 : 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (busy) bc++;
      if (disturb && !done) begin
        start = 1'b1; a = $urandom; b = $urandom; op = 3'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    g = sb.pop_front();
    if (!done) begin
      failures++; checks++;
      $display("FAIL %s timeout: no done within %0d cycles", name, n);
    end else begin
      chk({name, " latency"}, 64'(n), 64'(g.lat));
      chk({name, " busy_cycles"}, 64'(bc), 64'(g.bcyc));
      chk({name, " busy_in_done"}, 64'(busy), 64'd0);
      chk({name, " result"}, 64'(result), 64'(g.res));
      chk({name, " hi"}, 64'(hi), 64'(g.hi));
      chk({name, " zero"}, 64'(zero), 64'(g.z));
    end
    held = result;
    @(posedge clk); #1;
    chk({name, " done_pulse"}, 64'(done), 64'd0);
    chk({name, " result_hold"}, 64'(result), 64'(held));
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{3'b011, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 32'h0};
    vecs[1]  = '{3'b011, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0};
    vecs[2]  = '{3'b101, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0};
    vecs[3]  = '{3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0};
    vecs[4]  = '{3'b110, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0};
    vecs[5]  = '{3'b110, 32'h80000000, 32'h00000001, 32'h00000001, 32'h0};
    vecs[6]  = '{3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0};
    vecs[7]  = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0};
    vecs[8]  = '{3'b001, 32'h12340000, 32'h00005678, 32'h12345678, 32'h0};
    vecs[9]  = '{3'b010, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 32'h0};
    vecs[10] = '{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
    vecs[11] = '{3'b111, 32'h00000000, 32'h00012345, 32'h00000000, 32'h0};
    vecs[12] = '{3'b111, 32'h00000003, 32'h80000001, 32'h80000003, 32'h00000001};

    // Start asserted together with reset must be ignored
    reset = 1'b1; start = 1'b1; op = 3'b100; a = 32'h1; b = 32'h1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset zero", 64'(zero), 64'd1);
    @(posedge clk); #1;
    chk("start_with_reset ignored", 64'(busy), 64'd0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].hi, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] ro; logic [31:0] ra, rb; logic [63:0] m;
      ro = 3'($urandom); ra = $urandom; rb = $urandom;
      m = model(ro, ra, rb);
      run_op($sformatf("rnd%0d", i), ro, ra, rb, m[31:0], m[63:32], 1'b0);
    end

    // Start held and operands scrambled throughout a MULT
    run_op("ignored_inputs", 3'b111, 32'h00010000, 32'h00010000, 32'h0, 32'h00000001, 1'b1);
    @(posedge clk); #1;
    chk("ignored_inputs no_restart", 64'(busy), 64'd0);

    // Reset pulse during the 10th MUL cycle
    start = 1'b1; op = 3'b111; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort zero", 64'(zero), 64'd1);
    begin
      int seen = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done) seen++;
      end
      chk("abort no_done", 64'(seen), 64'd0);
    end
    run_op("after_abort AND", 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0);

    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
